// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder sequencer: symbol geometry,
// the default frequency counter width and the sequencer state encoding.
package huffman_pkg;

  localparam int SYM_W   = 4;
  localparam int NUM_SYM = 2 ** SYM_W;
  localparam int CNT_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNT      = 3'd1,
    ST_BUILD      = 3'd2,
    ST_WAIT_BUILD = 3'd3,
    ST_ENCODE     = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

endpackage

// File: rtl/huffman_freq_table.sv
// Symbol histogram: one saturating counter per symbol, synchronous clear,
// single increment port and an asynchronous read port for the tree builder.
module huffman_freq_table #(
  parameter int SYM_W = huffman_pkg::SYM_W,
  parameter int CNT_W = huffman_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [SYM_W-1:0] inc_addr_i,
  input  logic [SYM_W-1:0] rd_addr_i,
  output logic [CNT_W-1:0] rd_data_o
);

  localparam int NSYM = 2 ** SYM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NSYM];

  // Clear wins over increment; a full counter simply stops counting.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < NSYM; i++) cnt_q[i] <= '0;
    end else if (inc_i && (cnt_q[inc_addr_i] != CNT_MAX)) begin
      cnt_q[inc_addr_i] <= cnt_q[inc_addr_i] + 1'b1;
    end
  end

  assign rd_data_o = cnt_q[rd_addr_i];

endmodule

// File: rtl/huffman_seq.sv
// Phase sequencer for the Huffman encoder: histogram the input stream, launch
// the tree builder, then stream ENC_LEN symbols to the serializer.
module huffman_seq #(
  parameter int SYM_W      = huffman_pkg::SYM_W,
  parameter int CNT_W      = huffman_pkg::CNT_W,
  parameter int SAMPLE_LEN = 256,
  parameter int ENC_LEN    = 256
) (
  input  logic             Clk_in,
  input  logic             Rst,
  input  logic             Start,
  input  logic [SYM_W-1:0] Data_in,
  input  logic [SYM_W-1:0] Freq_rd_addr,
  output logic [CNT_W-1:0] Freq_rd_data,
  output logic             Build_start,
  input  logic             Build_done,
  output logic             Enc_valid,
  output logic [SYM_W-1:0] Enc_sym,
  input  logic             Enc_ready,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       Phase
);

  import huffman_pkg::*;

  localparam int SCNT_W = $clog2(SAMPLE_LEN + 1);
  localparam int XCNT_W = $clog2(ENC_LEN + 1);
  localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(SAMPLE_LEN - 1);
  localparam logic [XCNT_W-1:0] XFER_LAST   = XCNT_W'(ENC_LEN - 1);

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [XCNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [SYM_W-1:0]  enc_sym_q, enc_sym_d;
  logic              build_start_q, build_start_d;
  logic              enc_valid_q, enc_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer, table_clear, table_inc, run_start;

  assign run_start   = (state_q == ST_IDLE) && Start;
  assign xfer        = enc_valid_q && Enc_ready;
  assign table_clear = Rst || run_start;
  assign table_inc   = (state_q == ST_COUNT);

  huffman_freq_table #(.SYM_W(SYM_W), .CNT_W(CNT_W)) u_table (
    .clk_i      (Clk_in),
    .clear_i    (table_clear),
    .inc_i      (table_inc),
    .inc_addr_i (Data_in),
    .rd_addr_i  (Freq_rd_addr),
    .rd_data_o  (Freq_rd_data)
  );

  always_ff @(posedge Clk_in) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (Start) state_d = ST_COUNT;
      ST_COUNT:      if (sample_cnt_q == SAMPLE_LAST) state_d = ST_BUILD;
      ST_BUILD:      state_d = ST_WAIT_BUILD;
      ST_WAIT_BUILD: if (Build_done) state_d = ST_ENCODE;
      ST_ENCODE:     if (xfer && (xfer_cnt_q == XFER_LAST)) state_d = ST_DONE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    build_start_d = (state_d == ST_BUILD);
    enc_valid_d   = (state_d == ST_ENCODE);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    sample_cnt_d  = sample_cnt_q;
    xfer_cnt_d    = xfer_cnt_q;
    enc_sym_d     = enc_sym_q;
    if (run_start) begin
      sample_cnt_d = '0;
    end else if (state_q == ST_COUNT) begin
      sample_cnt_d = sample_cnt_q + 1'b1;
    end
    if ((state_q == ST_WAIT_BUILD) && Build_done) begin
      xfer_cnt_d = '0;
      enc_sym_d  = Data_in;
    end else if (xfer) begin
      xfer_cnt_d = xfer_cnt_q + 1'b1;
      enc_sym_d  = Data_in;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      sample_cnt_q  <= '0;
      xfer_cnt_q    <= '0;
      enc_sym_q     <= '0;
      build_start_q <= 1'b0;
      enc_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      sample_cnt_q  <= sample_cnt_d;
      xfer_cnt_q    <= xfer_cnt_d;
      enc_sym_q     <= enc_sym_d;
      build_start_q <= build_start_d;
      enc_valid_q   <= enc_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign Build_start = build_start_q;
  assign Enc_valid   = enc_valid_q;
  assign Enc_sym     = enc_sym_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Phase       = state_q;

endmodule

// File: tb/tb_huffman_seq.sv
// Self-checking bench for huffman_seq: a histogram/stream reference model feeds
// a scoreboard that a separate monitor drains on every serializer handshake.
module tb_huffman_seq;

  localparam int SYM_W      = 4;
  localparam int CNT_W      = 10;
  localparam int SAT_W      = 3;
  localparam int SAMPLE_LEN = 16;
  localparam int ENC_LEN    = 4;
  localparam int SAT_MAX    = 2 ** SAT_W - 1;

  logic             clk, rst, start, buildDone, encReady;
  logic [SYM_W-1:0] dataIn, rdAddr;
  logic [CNT_W-1:0] rdData;
  logic             buildStart, encValid, busy, done;
  logic [SYM_W-1:0] encSym;
  logic [2:0]       phase;
  logic [SAT_W-1:0] rdDataSat;
  logic             buildStartSat, encValidSat, busySat, doneSat;
  logic [SYM_W-1:0] encSymSat;
  logic [2:0]       phaseSat;

  int errors = 0;
  int checks = 0;
  int monXfers = 0;
  int expXfers = 0;
  int donePulses = 0;
  int hist [16];
  logic [SYM_W-1:0] sb [$];

  huffman_seq #(.SYM_W(SYM_W), .CNT_W(CNT_W), .SAMPLE_LEN(SAMPLE_LEN), .ENC_LEN(ENC_LEN)) dut (
    .Clk_in(clk), .Rst(rst), .Start(start), .Data_in(dataIn),
    .Freq_rd_addr(rdAddr), .Freq_rd_data(rdData), .Build_start(buildStart),
    .Build_done(buildDone), .Enc_valid(encValid), .Enc_sym(encSym),
    .Enc_ready(encReady), .Busy(busy), .Done(done), .Phase(phase)
  );

  // Narrow-counter twin sharing the same stimulus, used for saturation.
  huffman_seq #(.SYM_W(SYM_W), .CNT_W(SAT_W), .SAMPLE_LEN(SAMPLE_LEN), .ENC_LEN(ENC_LEN)) dutSat (
    .Clk_in(clk), .Rst(rst), .Start(start), .Data_in(dataIn),
    .Freq_rd_addr(rdAddr), .Freq_rd_data(rdDataSat), .Build_start(buildStartSat),
    .Build_done(buildDone), .Enc_valid(encValidSat), .Enc_sym(encSymSat),
    .Enc_ready(encReady), .Busy(busySat), .Done(doneSat), .Phase(phaseSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid cycle is checked against the scoreboard head.
  always @(negedge clk) begin
    if (done) donePulses++;
    if (encValid) begin
      if (sb.size() == 0) begin
        checkOutput("encUnderflow", 32'(encSym), 32'hFFFF);
      end else if (encReady) begin
        checkOutput("encSym", 32'(encSym), 32'(sb.pop_front()));
        monXfers++;
      end else begin
        checkOutput("encHold", 32'(encSym), 32'(sb[0]));
      end
    end
  end

  task automatic checkTable(input string tag);
    for (int a = 0; a < 16; a++) begin
      int expSat;
      rdAddr = SYM_W'(a);
      #1;
      expSat = (hist[a] > SAT_MAX) ? SAT_MAX : hist[a];
      checkOutput($sformatf("%s[%0d]", tag, a), 32'(rdData), hist[a]);
      checkOutput($sformatf("%sSat[%0d]", tag, a), 32'(rdDataSat), expSat);
    end
  endtask

  // dataMode: 0 histogram pattern, 1 all 9, 2 all 5, 3 random.
  // encMode: 0 random ready, 1 ready 0,0,1 with data 9, 2 ready always high.
  task automatic applyStimulus(input int dataMode, input int encMode, input bit spurious,
                               input bit midReset);
    int d, xfers, cyc;
    bit rdy;
    for (int a = 0; a < 16; a++) hist[a] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("phaseCount", 32'(phase), 1);
    checkOutput("busyStart", 32'(busy), 1);
    for (int i = 0; i < SAMPLE_LEN; i++) begin
      case (dataMode)
        0:       d = (i < 10) ? 0 : 3;
        1:       d = 9;
        2:       d = 5;
        default: d = int'($urandom_range(0, 15));
      endcase
      dataIn = SYM_W'(d);
      hist[d]++;
      if (spurious) begin
        start     = (i == 4);
        buildDone = (i == 7);
      end
      tick();
      start     = 1'b0;
      buildDone = 1'b0;
      checkOutput($sformatf("buildStart@%0d", i + 2), 32'(buildStart), (i == SAMPLE_LEN - 1) ? 1 : 0);
      checkOutput($sformatf("phase@%0d", i + 2), 32'(phase), (i == SAMPLE_LEN - 1) ? 2 : 1);
    end
    tick();
    checkOutput("phaseWait", 32'(phase), 3);
    checkOutput("buildStartOff", 32'(buildStart), 0);
    dataIn = SYM_W'($urandom_range(0, 15));
    checkTable("freq");
    for (int k = 0; k < 3; k++) begin
      tick();
      dataIn = SYM_W'($urandom_range(0, 15));
      checkOutput("waitHold", 32'(phase), 3);
    end
    d = (encMode == 1) ? 9 : int'($urandom_range(0, 15));
    dataIn    = SYM_W'(d);
    buildDone = 1'b1;
    sb.push_back(SYM_W'(d));
    tick();
    buildDone = 1'b0;
    checkOutput("encEntry", 32'(encValid), 1);
    xfers = 0;
    cyc   = 0;
    while (xfers < ENC_LEN && cyc < 200) begin
      if (midReset && xfers == 2) break;
      case (encMode)
        0:       rdy = 1'($urandom_range(0, 1));
        1:       rdy = (cyc % 3 == 2);
        default: rdy = 1'b1;
      endcase
      d = (encMode == 1) ? 9 : int'($urandom_range(0, 15));
      encReady = rdy;
      dataIn   = SYM_W'(d);
      if (rdy) begin
        xfers++;
        expXfers++;
        if (xfers < ENC_LEN) sb.push_back(SYM_W'(d));
      end
      tick();
      cyc++;
    end
    encReady = 1'b0;
    if (midReset) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      for (int a = 0; a < 16; a++) hist[a] = 0;
      checkOutput("rstPhase", 32'(phase), 0);
      checkOutput("rstEncValid", 32'(encValid), 0);
      checkOutput("rstEncSym", 32'(encSym), 0);
      checkOutput("rstBusy", 32'(busy), 0);
      checkTable("rstFreq");
      return;
    end
    if (xfers < ENC_LEN) checkOutput("encTimeout", xfers, ENC_LEN);
    checkOutput("donePulse", 32'(done), 1);
    checkOutput("phaseDone", 32'(phase), 5);
    checkOutput("encValidDrop", 32'(encValid), 0);
    checkOutput("busyDone", 32'(busy), 1);
    tick();
    checkOutput("doneOff", 32'(done), 0);
    checkOutput("phaseIdle", 32'(phase), 0);
    checkOutput("busyIdle", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; buildDone = 1'b0; encReady = 1'b0;
    dataIn = '0; rdAddr = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) hist[a] = 0;
    checkOutput("resetPhase", 32'(phase), 0);
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetDone", 32'(done), 0);
    checkOutput("resetEncValid", 32'(encValid), 0);
    checkOutput("resetEncSym", 32'(encSym), 0);
    checkOutput("resetBuildStart", 32'(buildStart), 0);
    checkTable("resetFreq");

    $display("[TB] histogram run");
    applyStimulus(0, 2, 1'b0, 1'b0);
    $display("[TB] backpressure run");
    applyStimulus(1, 1, 1'b0, 1'b0);
    $display("[TB] saturation and spurious-input run");
    applyStimulus(2, 0, 1'b1, 1'b0);
    $display("[TB] reset during encode");
    applyStimulus(3, 2, 1'b0, 1'b1);
    $display("[TB] fresh run after reset");
    applyStimulus(3, 0, 1'b1, 1'b0);

    $display("[TB] reset and start together");
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rstStartPhase", 32'(phase), 0);
    checkOutput("rstStartBusy", 32'(busy), 0);
    tick();
    checkOutput("rstStartStay", 32'(phase), 0);

    tick();
    checkOutput("xferCount", monXfers, expXfers);
    checkOutput("sbEmpty", sb.size(), 0);
    checkOutput("donePulses", donePulses, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/huffman_seq.md
# huffman_seq

Phase sequencer for the Huffman encoder datapath. On a Start pulse it gathers a symbol histogram from the 4-bit input stream, hands the frequency table to the tree builder and waits for it to finish. It then feeds a fixed number of symbols, one per handshake, to the code serializer and signals completion. It sits between the top-level input pins and the tree-builder/serializer pair, and owns the frequency table.

## Interface
- SYM_W, default 4: symbol width; NUM_SYM = 2**SYM_W table entries.
- CNT_W, default 10: per-symbol frequency counter width.
- SAMPLE_LEN, default 256: cycles sampled in the COUNT phase.
- ENC_LEN, default 256: symbols handed to the serializer in the ENCODE phase.
- Clk_in  in  1  sole clock; all logic on its rising edge.
- Rst  in  1  reset, synchronous and active-high.
- Start  in  1  one-cycle run request; honoured only in IDLE.
- Data_in  in  SYM_W  raw symbol stream.
- Freq_rd_addr  in  SYM_W  tree-builder read address into the frequency table.
- Freq_rd_data  out  CNT_W  combinational read of counter[Freq_rd_addr].
- Build_start  out  1  one-cycle pulse that launches the tree builder.
- Build_done  in  1  tree builder finished; sampled only in WAIT_BUILD.
- Enc_valid  out  1  Enc_sym is valid for the serializer.
- Enc_sym  out  SYM_W  symbol to encode.
- Enc_ready  in  1  serializer can accept a symbol.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at the end of a run.
- Phase  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, COUNT=1, BUILD=2, WAIT_BUILD=3, ENCODE=4, DONE=5.
- IDLE: wait for Start.
  - Start=1 moves to COUNT on the next cycle.
  - The same edge clears all NUM_SYM counters and the sample counter.
- COUNT: every cycle, counter[Data_in] increments.
  - Counters saturate at 2**CNT_W-1 and never wrap.
  - After exactly SAMPLE_LEN sampled cycles, go to BUILD.
- BUILD: lasts one cycle, with Build_start=1. Then go to WAIT_BUILD.
- WAIT_BUILD: hold until Build_done=1, then go to ENCODE.
  - The counters are frozen here and stay frozen through ENCODE and DONE.
  - Freq_rd_data is valid in every state.
- ENCODE: Enc_valid=1.
  - Enc_sym is the Data_in value registered on the entry edge.
  - A transfer happens on any cycle with Enc_valid and Enc_ready both high.
  - On a transfer edge, Enc_sym reloads from the current Data_in.
  - Enc_sym stays stable while Enc_ready=0.
  - When the transfer count reaches ENC_LEN, go to DONE. Enc_valid drops on that same edge.
- DONE: lasts one cycle, with Done=1, then returns to IDLE.
- Start outside IDLE is ignored. A stray Build_done outside WAIT_BUILD is ignored.
- Rst=1 in any state, mid-run included, acts on the next edge:
  - state goes to IDLE; counters, sample and transfer counts, and Enc_sym go to 0;
  - Rst has priority over Start.

## Timing
- Reset values: Build_start=0, Enc_valid=0, Enc_sym=0, Busy=0, Done=0, Phase=0, all counters 0.
- Start high at edge t: Busy=1 and Phase=1 from t+1.
- COUNT samples at edges t+1 through t+SAMPLE_LEN. Build_start is high during cycle t+SAMPLE_LEN+1.
- Build_done high at edge b: Enc_valid=1 from b+1.
- With Enc_ready held high: the last transfer is at edge b+ENC_LEN, and Done is high for the cycle after it.
- Minimum run length from Start to Done, with Build_done returned in 1 cycle: SAMPLE_LEN+ENC_LEN+4 cycles.
- All outputs are registered except Freq_rd_data.
- Sample and transfer counters are wide enough to hold the SAMPLE_LEN and ENC_LEN terminal values.

## Structure
- Shared package huffman_pkg holds:
  - the state encodings;
  - SYM_W and NUM_SYM;
  - the CNT_W default.
- One natural sub-module, huffman_freq_table:
  - NUM_SYM saturating counters with a synchronous clear and an increment port;
  - an asynchronous read port.
- FSM, sample counter, transfer counter and handshake logic live in huffman_seq.

## Test plan
- Test configuration: SAMPLE_LEN=16, ENC_LEN=4.
- Histogram run:
  - stimulus: Start; Data_in=0 for 10 cycles, then 3 for 6 cycles;
  - expected: read counter[0]=10, counter[3]=6, all others 0; Build_start pulses exactly once at cycle 17 after Start.
- Saturation:
  - stimulus: CNT_W=3, Data_in held at 5 for the whole COUNT phase;
  - expected: counter[5]=7 with no wrap.
- Encode backpressure:
  - stimulus: Data_in=9; Enc_ready toggles 0,0,1 repeatedly;
  - expected: Enc_sym holds 9 while Enc_ready is low; exactly 4 transfers; Done pulses once; then IDLE with Busy=0.
- Spurious inputs:
  - stimulus: Start pulsed during COUNT; Build_done pulsed during COUNT;
  - expected: no restart, no early exit from COUNT; WAIT_BUILD still waits for the real Build_done.
- Reset mid-run:
  - stimulus: Rst=1 for one cycle during ENCODE;
  - expected: next cycle Phase=0, Enc_valid=0, all counters 0; a fresh Start then runs normally.
- Rst and Start high on the same edge:
  - expected: the block stays in IDLE.
